// File: rtl/jtag_bscan_tap.sv
// IEEE 1149.1 TAP controller with a 2*NUM_IO-cell boundary-scan register and pad/core muxing.
// Optional macro JTAG_USERCODE_EN: when defined, opcode 8 selects the 32-bit USERCODE register.
module jtag_bscan_tap #(
  parameter int unsigned IR_WIDTH       = 4,
  parameter int unsigned NUM_IO         = 4,
  parameter logic [31:0] IDCODE_VALUE   = 32'h1000_0001,
  parameter logic [31:0] USERCODE_VALUE = 32'h0000_0000
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  input  logic [NUM_IO-1:0]   PIN_IN,
  input  logic [NUM_IO-1:0]   CORE_OUT,
  output logic [NUM_IO-1:0]   PAD_OUT,
  output logic                PAD_OE,
  output logic [NUM_IO-1:0]   CORE_IN,
  output logic [IR_WIDTH-1:0] IR_OUT,
  output logic                TLR
);

  localparam int unsigned BSR_LEN = 2 * NUM_IO;

  localparam logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_EXTEST   = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_INTEST   = IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] OP_CLAMP    = IR_WIDTH'(5);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(7);
`ifdef JTAG_USERCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(8);
`endif
  localparam logic [IR_WIDTH-1:0] OP_HIGHZ    = IR_WIDTH'(9);

  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SELDR, S_CAPDR, S_SHDR, S_EX1DR, S_PAUDR, S_EX2DR, S_UPDDR,
    S_SELIR, S_CAPIR, S_SHIR, S_EX1IR, S_PAUIR, S_EX2IR, S_UPDIR
  } state_e;

  typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_UC, SEL_BSR} sel_e;

  state_e               state, state_nxt;
  sel_e                 sel;
  logic [IR_WIDTH-1:0]  ir_shift;
  logic                 byp;
  logic [31:0]          dr32;
  logic [31:0]          cap32;
  logic [BSR_LEN-1:0]   bsr_shift;
  logic [BSR_LEN-1:0]   bsr_upd;

  // TAP next-state on TMS
  always_comb begin
    state_nxt = state;
    case (state)
      S_TLR:   state_nxt = TMS ? S_TLR   : S_RTI;
      S_RTI:   state_nxt = TMS ? S_SELDR : S_RTI;
      S_SELDR: state_nxt = TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: state_nxt = TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  state_nxt = TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: state_nxt = TMS ? S_UPDDR : S_PAUDR;
      S_PAUDR: state_nxt = TMS ? S_EX2DR : S_PAUDR;
      S_EX2DR: state_nxt = TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: state_nxt = TMS ? S_SELDR : S_RTI;
      S_SELIR: state_nxt = TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: state_nxt = TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  state_nxt = TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: state_nxt = TMS ? S_UPDIR : S_PAUIR;
      S_PAUIR: state_nxt = TMS ? S_EX2IR : S_PAUIR;
      S_EX2IR: state_nxt = TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: state_nxt = TMS ? S_SELDR : S_RTI;
      default: state_nxt = S_TLR;
    endcase
  end

  // Data-register selection from the active instruction; unknown codes fall back to bypass
  always_comb begin
    sel = SEL_BYP;
    case (IR_OUT)
      OP_SAMPLE, OP_EXTEST, OP_INTEST: sel = SEL_BSR;
      OP_IDCODE:                       sel = SEL_ID;
`ifdef JTAG_USERCODE_EN
      OP_USERCODE:                     sel = SEL_UC;
`endif
      default:                         sel = SEL_BYP;
    endcase
  end

  // IDCODE and USERCODE share one 32-bit shift stage
  assign cap32 = (sel == SEL_UC) ? USERCODE_VALUE : IDCODE_VALUE;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state     <= S_TLR;
      ir_shift  <= '0;
      IR_OUT    <= OP_IDCODE;
      byp       <= 1'b0;
      dr32      <= '0;
      bsr_shift <= '0;
      bsr_upd   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_CAPIR: ir_shift <= IR_WIDTH'(1);
        S_SHIR:  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        S_CAPDR: begin
          case (sel)
            SEL_BSR: bsr_shift <= {CORE_OUT, PIN_IN};
            SEL_BYP: byp       <= 1'b0;
            default: dr32      <= cap32;
          endcase
        end
        S_SHDR: begin
          case (sel)
            SEL_BSR: bsr_shift <= {TDI, bsr_shift[BSR_LEN-1:1]};
            SEL_BYP: byp       <= TDI;
            default: dr32      <= {TDI, dr32[31:1]};
          endcase
        end
        S_UPDDR: if (sel == SEL_BSR) bsr_upd <= bsr_shift;
        default: ;
      endcase
      // Entering TLR restores IDCODE on the same edge; update stages are kept
      if (state_nxt == S_TLR) IR_OUT <= OP_IDCODE;
      else if (state == S_UPDIR) IR_OUT <= ir_shift;
    end
  end

  // Serial output driven from register LSBs only
  always_comb begin
    TDO    = 1'b0;
    TDO_EN = 1'b0;
    if (state == S_SHIR) begin
      TDO    = ir_shift[0];
      TDO_EN = 1'b1;
    end else if (state == S_SHDR) begin
      TDO_EN = 1'b1;
      case (sel)
        SEL_BSR: TDO = bsr_shift[0];
        SEL_BYP: TDO = byp;
        default: TDO = dr32[0];
      endcase
    end
  end

  assign TLR     = (state == S_TLR);
  assign PAD_OUT = ((IR_OUT == OP_EXTEST) || (IR_OUT == OP_CLAMP)) ? bsr_upd[BSR_LEN-1:NUM_IO] : CORE_OUT;
  assign CORE_IN = (IR_OUT == OP_INTEST) ? bsr_upd[NUM_IO-1:0] : PIN_IN;
  assign PAD_OE  = (IR_OUT != OP_HIGHZ);

endmodule

// File: tb/tb_jtag_bscan_tap.sv
// Directed self-checking bench for jtag_bscan_tap (default parameters).
module tb_jtag_bscan_tap;

  logic       TCK, TRST, TMS, TDI;
  logic       TDO, TDO_EN, PAD_OE, TLR;
  logic [3:0] PIN_IN, CORE_OUT, PAD_OUT, CORE_IN, IR_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] dout;

  jtag_bscan_tap dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .PIN_IN(PIN_IN), .CORE_OUT(CORE_OUT), .PAD_OUT(PAD_OUT), .PAD_OE(PAD_OE),
    .CORE_IN(CORE_IN), .IR_OUT(IR_OUT), .TLR(TLR)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // From RTI: shift n IR bits LSB-first, update, return to RTI
  task automatic shift_ir(input logic [63:0] din, input int n, output logic [63:0] q);
    q = '0;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("tdo_en_shir", 64'(TDO_EN), 64'd1);
    for (int i = 0; i < n; i++) begin
      q[i] = TDO;
      step(i == n - 1, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RTI: capture, shift n DR bits LSB-first, update, return to RTI
  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] q);
    q = '0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      q[i] = TDO;
      step(i == n - 1, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    TRST = 1'b0; TMS = 1'b1; TDI = 1'b0;
    PIN_IN = 4'h3; CORE_OUT = 4'h5;
    #12;
    chk("rst_tlr",     64'(TLR),     64'd1);
    chk("rst_ir",      64'(IR_OUT),  64'h7);
    chk("rst_tdo",     64'(TDO),     64'd0);
    chk("rst_tdo_en",  64'(TDO_EN),  64'd0);
    chk("rst_pad_out", 64'(PAD_OUT), 64'h5);
    chk("rst_core_in", 64'(CORE_IN), 64'h3);
    chk("rst_pad_oe",  64'(PAD_OE),  64'd1);
    #5 TRST = 1'b1;
    step(1'b0, 1'b0);
    chk("rti_tlr", 64'(TLR), 64'd0);

    // IDCODE then TDI bits emerge after 32 shifts
    shift_dr(64'h0000_0000_0000_00C3, 40, dout);
    chk("idcode",       64'(dout[31:0]),  64'h1000_0001);
    chk("idcode_trail", 64'(dout[39:32]), 64'hC3);

    // IR capture pattern and BYPASS load
    shift_ir(64'hF, 4, dout);
    chk("ir_capture", 64'(dout[3:0]), 64'h1);
    chk("ir_bypass",  64'(IR_OUT),    64'hF);
    shift_dr(64'hB6, 8, dout);
    chk("bypass_delay", 64'(dout[7:0]), 64'h6C);

    // Five TMS=1 from RTI reach TLR and restore IDCODE
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("tms_rst_tlr", 64'(TLR),     64'd1);
    chk("tms_rst_ir",  64'(IR_OUT),  64'h7);
    chk("tms_rst_pad", 64'(PAD_OUT), 64'h5);
    step(1'b0, 1'b0);

    // SAMPLE/PRELOAD: capture pads, preload output cells with A
    shift_ir(64'h1, 4, dout);
    shift_dr(64'hA0, 8, dout);
    chk("sample_cap", 64'(dout[7:0]), 64'h53);
    chk("sample_pad", 64'(PAD_OUT),   64'h5);

    // EXTEST drives preloaded cells; core changes ignored
    shift_ir(64'h2, 4, dout);
    chk("extest_pad", 64'(PAD_OUT), 64'hA);
    CORE_OUT = 4'hC;
    #1;
    chk("extest_core_ignored", 64'(PAD_OUT), 64'hA);

    shift_ir(64'h9, 4, dout);
    chk("highz_oe",  64'(PAD_OE),  64'd0);
    chk("highz_pad", 64'(PAD_OUT), 64'hC);

    shift_ir(64'h5, 4, dout);
    chk("clamp_pad", 64'(PAD_OUT), 64'hA);
    chk("clamp_oe",  64'(PAD_OE),  64'd1);

    // INTEST: input cells drive the core
    shift_ir(64'h3, 4, dout);
    shift_dr(64'hAC, 8, dout);
    chk("intest_cap",     64'(dout[7:0]), 64'hC3);
    chk("intest_core_in", 64'(CORE_IN),   64'hC);
    chk("intest_pad",     64'(PAD_OUT),   64'hC);
    shift_dr(64'hAC, 8, dout);
    chk("intest_recap", 64'(dout[3:0]), 64'h3);
    chk("intest_hold",  64'(CORE_IN),   64'hC);

    // TRST mid-shift
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("midshift_en", 64'(TDO_EN), 64'd1);
    TRST = 1'b0;
    #2;
    chk("trst_tlr",     64'(TLR),     64'd1);
    chk("trst_ir",      64'(IR_OUT),  64'h7);
    chk("trst_tdo_en",  64'(TDO_EN),  64'd0);
    chk("trst_core_in", 64'(CORE_IN), 64'h3);
    chk("trst_pad_out", 64'(PAD_OUT), 64'hC);
    #1 TRST = 1'b1;
    step(1'b0, 1'b0);

    // Opcode 8: USERCODE with the macro, otherwise bypass
    shift_ir(64'h8, 4, dout);
`ifdef JTAG_USERCODE_EN
    shift_dr(64'hFF_FFFF_FFFF, 40, dout);
    chk("usercode", 64'(dout[39:0]), 64'hFF_0000_0000);
`else
    shift_dr(64'hFF, 8, dout);
    chk("usercode_bypass", 64'(dout[7:0]), 64'hFE);
`endif

    // Undefined opcode decodes as bypass
    shift_ir(64'h6, 4, dout);
    shift_dr(64'h01, 8, dout);
    chk("unknown_bypass", 64'(dout[7:0]), 64'h02);

    // IDCODE read interrupted by Pause-DR
    shift_ir(64'h7, 4, dout);
    dout = '0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dout[i] = TDO;
      step(i == 3, 1'b0);
    end
    step(1'b0, 1'b0);
    chk("pause_tdo_en", 64'(TDO_EN), 64'd0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 4; i < 32; i++) begin
      dout[i] = TDO;
      step(i == 31, 1'b0);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("pause_idcode", 64'(dout[31:0]), 64'h1000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
